// File: rtl/datapath.sv
// Processor datapath: the architectural registers, the Z flag, the shared bus mux and the ALU.
// All state changes on posedge CLK. RESET is synchronous and active-low.
module datapath #(
  parameter int DATA_W = 8
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              PCINC,
  input  logic              D_W,
  input  logic              FINISH,
  input  logic [3:0]        ALU_SEL,
  input  logic [2:0]        B_SEL,
  input  logic [7:0]        REG_LOAD,
  input  logic [DATA_W-1:0] IMEM_DATA,
  input  logic [DATA_W-1:0] DMEM_RDATA,
  output logic [DATA_W-1:0] IMEM_ADDR,
  output logic [DATA_W-1:0] DMEM_ADDR,
  output logic [DATA_W-1:0] DMEM_WDATA,
  output logic              DMEM_WE,
  output logic [DATA_W-1:0] IR,
  output logic              Z,
  output logic [DATA_W-1:0] AC_OUT,
  output logic              HALTED
);

  localparam logic [3:0] ALU_PASS_A = 4'd0;
  localparam logic [3:0] ALU_PASS_B = 4'd1;
  localparam logic [3:0] ALU_ADD    = 4'd2;
  localparam logic [3:0] ALU_SUB    = 4'd3;
  localparam logic [3:0] ALU_INC    = 4'd4;
  localparam logic [3:0] ALU_ZERO   = 4'd5;
  localparam logic [3:0] ALU_AND    = 4'd9;
  localparam logic [3:0] ALU_OR     = 4'd10;
  localparam logic [3:0] ALU_XOR    = 4'd11;
  localparam logic [3:0] ALU_NOT    = 4'd12;

  localparam logic [DATA_W-1:0] ONE = {{(DATA_W-1){1'b0}}, 1'b1};

  logic [DATA_W-1:0] ar_q, ac_q, pc_q, r_q, s_q, t_q, u_q, ir_q;
  logic [DATA_W-1:0] ar_d, ac_d, pc_d, r_d, s_d, t_d, u_d, ir_d;
  logic              z_q, z_d;
  logic              halted_q, halted_d;
  logic [DATA_W-1:0] bus;
  logic [DATA_W-1:0] alu;

  always_comb begin
    bus = DMEM_RDATA;
    case (B_SEL)
      3'd0:    bus = DMEM_RDATA;
      3'd1:    bus = IMEM_DATA;
      3'd2:    bus = pc_q;
      3'd3:    bus = r_q;
      3'd4:    bus = s_q;
      3'd5:    bus = t_q;
      3'd6:    bus = u_q;
      default: bus = ac_q;
    endcase
  end

  // Unassigned ALU codes pass AC through so a stray code never corrupts the accumulator.
  always_comb begin
    alu = ac_q;
    case (ALU_SEL)
      ALU_PASS_A: alu = ac_q;
      ALU_PASS_B: alu = bus;
      ALU_ADD:    alu = ac_q + bus;
      ALU_SUB:    alu = ac_q - bus;
      ALU_INC:    alu = ac_q + ONE;
      ALU_ZERO:   alu = '0;
      ALU_AND:    alu = ac_q & bus;
      ALU_OR:     alu = ac_q | bus;
      ALU_XOR:    alu = ac_q ^ bus;
      ALU_NOT:    alu = ~ac_q;
      default:    alu = ac_q;
    endcase
  end

  // Once halted nothing moves; the FINISH cycle itself still commits its loads.
  always_comb begin
    ar_d     = ar_q;
    ac_d     = ac_q;
    pc_d     = pc_q;
    r_d      = r_q;
    s_d      = s_q;
    t_d      = t_q;
    u_d      = u_q;
    ir_d     = ir_q;
    z_d      = z_q;
    halted_d = halted_q;
    if (!halted_q) begin
      if (REG_LOAD[0]) ar_d = bus;
      if (REG_LOAD[1]) begin
        ac_d = alu;
        z_d  = (alu == '0);
      end
      if (REG_LOAD[2])  pc_d = bus;
      else if (PCINC)   pc_d = pc_q + ONE;
      if (REG_LOAD[3]) r_d  = bus;
      if (REG_LOAD[4]) s_d  = bus;
      if (REG_LOAD[5]) t_d  = bus;
      if (REG_LOAD[6]) u_d  = bus;
      if (REG_LOAD[7]) ir_d = bus;
      if (FINISH)      halted_d = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      ar_q     <= '0;
      ac_q     <= '0;
      pc_q     <= '0;
      r_q      <= '0;
      s_q      <= '0;
      t_q      <= '0;
      u_q      <= '0;
      ir_q     <= '0;
      z_q      <= 1'b1;
      halted_q <= 1'b0;
    end else begin
      ar_q     <= ar_d;
      ac_q     <= ac_d;
      pc_q     <= pc_d;
      r_q      <= r_d;
      s_q      <= s_d;
      t_q      <= t_d;
      u_q      <= u_d;
      ir_q     <= ir_d;
      z_q      <= z_d;
      halted_q <= halted_d;
    end
  end

  assign IMEM_ADDR  = pc_q;
  assign DMEM_ADDR  = ar_q;
  assign DMEM_WDATA = ac_q;
  assign DMEM_WE    = D_W & ~halted_q;
  assign IR         = ir_q;
  assign Z          = z_q;
  assign AC_OUT     = ac_q;
  assign HALTED     = halted_q;

endmodule
